// File: rtl/sub_seq_cla.sv
// Sequential subtractor: one 4-bit carry-lookahead nibble per cycle.
// Optional signed-overflow port `ovf` is enabled by SUB_SEQ_OVF_EN.
module sub_seq_cla #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero
`ifdef SUB_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic             rdy_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [3:0]       an;
    logic [3:0]       bn;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum;
    logic [WIDTH-1:0] diff_nx;

`ifdef SUB_SEQ_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    // Held low in reset so nothing upstream sees a ready that won't be honoured.
    assign in_ready = rdy_q & rst_n;

    always_comb begin
        an = a_q[cnt*4 +: 4];
        bn = ~b_q[cnt*4 +: 4];
        g  = an & bn;
        p  = an ^ bn;
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & carry);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry);
        c[4] = g[3] | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (&p & carry);
        sum = p ^ c[3:0];
        diff_nx = diff;
        diff_nx[cnt*4 +: 4] = sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy_q     <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            diff      <= '0;
            b_out     <= 1'b0;
            zero      <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= '0;
                        carry <= ~b_in;
                        rdy_q <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    diff  <= diff_nx;
                    carry <= c[4];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        b_out     <= ~c[4];
                        zero      <= (diff_nx == '0);
`ifdef SUB_SEQ_OVF_EN
                        ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1])
                              && (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rdy_q     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq_cla.sv
// Directed bench for sub_seq_cla (WIDTH=16).
// Checks ovf only when built with SUB_SEQ_OVF_EN.
module tb_sub_seq_cla;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        b_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        b_out;
    logic        zero;
`ifdef SUB_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    sub_seq_cla #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .zero      (zero)
`ifdef SUB_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Presents one operand set, waits (bounded) for out_valid.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb,
                         input logic vbin, output int lat);
        a = va;
        b = vb;
        b_in = vbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic xfer();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h0101;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (diff !== 16'h0000) begin
            errors++;
            $display("FAIL reset_diff got %h exp 0000", diff);
        end
        checks++;
        if (b_out !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got b_out=%b zero=%b exp 0 0",
                     b_out, zero);
        end
`ifdef SUB_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b exp 0", ovf);
        end
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b exp 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ta[3];
        logic [15:0] tb[3];
        logic        tbin[3];
        logic [15:0] td[3];
        logic        tbo[3];
        logic        tz[3];
        int lat;
        ta = '{16'h1234, 16'h0000, 16'h5555};
        tb = '{16'h0234, 16'h0001, 16'h5554};
        tbin = '{1'b0, 1'b0, 1'b1};
        td = '{16'h1000, 16'hFFFF, 16'h0000};
        tbo = '{1'b0, 1'b1, 1'b0};
        tz = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], tbin[i], lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL basic%0d_latency got %0d exp 4", i, lat);
            end
            checks++;
            if (diff !== td[i]) begin
                errors++;
                $display("FAIL basic%0d_diff got %h exp %h", i, diff, td[i]);
            end
            checks++;
            if (b_out !== tbo[i]) begin
                errors++;
                $display("FAIL basic%0d_b_out got %b exp %b", i, b_out, tbo[i]);
            end
            checks++;
            if (zero !== tz[i]) begin
                errors++;
                $display("FAIL basic%0d_zero got %b exp %b", i, zero, tz[i]);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d_done_ready got %b exp 0", i, in_ready);
            end
            xfer();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic%0d_idle got out_valid=%b in_ready=%b exp 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

`ifdef SUB_SEQ_OVF_EN
    task automatic test_ovf();
        int lat;
        do_op(16'h8000, 16'h0001, 1'b0, lat);
        checks++;
        if (diff !== 16'h7FFF || b_out !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg got diff=%h b_out=%b ovf=%b exp 7fff 0 1",
                     diff, b_out, ovf);
        end
        xfer();
        do_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
        checks++;
        if (diff !== 16'h8000 || b_out !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos got diff=%h b_out=%b ovf=%b exp 8000 1 1",
                     diff, b_out, ovf);
        end
        xfer();
        do_op(16'h0000, 16'h0001, 1'b0, lat);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_none got %b exp 0", ovf);
        end
        xfer();
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        do_op(16'h1234, 16'h0234, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'hAAAA + 16'(i);
            b = 16'(i);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp%0d_hs got out_valid=%b in_ready=%b exp 1 0",
                         i, out_valid, in_ready);
            end
            checks++;
            if (diff !== 16'h1000 || b_out !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL bp%0d_hold got diff=%h b_out=%b zero=%b exp 1000 0 0",
                         i, diff, b_out, zero);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0 1",
                     out_valid, in_ready);
        end
        do_op(16'h0009, 16'h0004, 1'b0, lat);
        checks++;
        if (lat != 4 || diff !== 16'h0005) begin
            errors++;
            $display("FAIL bp_next got lat=%0d diff=%h exp 4 0005", lat, diff);
        end
        xfer();
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        a = 16'hFFFF;
        b = 16'h0001;
        b_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_ready got %b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (diff !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear got diff=%h out_valid=%b exp 0000 0",
                     diff, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_valid got 1 exp 0");
        end
        do_op(16'h0010, 16'h0001, 1'b0, lat);
        checks++;
        if (lat != 4 || diff !== 16'h000F || b_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_next got lat=%0d diff=%h b_out=%b exp 4 000f 0",
                     lat, diff, b_out);
        end
        xfer();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        bit bad;
        first = -1;
        second = -1;
        bad = 1'b0;
        a = 16'h0003;
        b = 16'h0001;
        b_in = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (diff !== 16'h0002) bad = 1'b1;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (first != 4 || second - first != 6) begin
            errors++;
            $display("FAIL b2b_rate got first=%0d gap=%0d exp 4 6",
                     first, second - first);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL b2b_diff got wrong diff exp 0002");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SUB_SEQ_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_seq_cla.md
SUB_SEQ_CLA -- requirements
Module: sub_seq_cla

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  minuend, unsigned/two's-complement.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 b_in  input  1  borrow in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 diff  output  WIDTH  a - b - b_in modulo 2^WIDTH.
REQ-012 b_out  output  1  borrow out; 1 iff a < b + b_in (unsigned).
REQ-013 zero  output  1  1 iff diff == 0.
REQ-014 ovf  output  1  signed overflow; present only per REQ-030.

Function
REQ-015 Subtraction SHALL be computed as a + ~b + ~b_in with one 4-bit carry-lookahead nibble slice per cycle, LSB nibble first; b_out = inverse of final carry.
REQ-016 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL capture a, b, b_in, clear nibble counter, preset carry = ~b_in, go to BUSY.
REQ-018 BUSY: in_ready=0, out_valid=0; each cycle processes nibble[counter], writes diff nibble, updates carry, increments counter.
REQ-019 After nibble WIDTH/4-1 is processed the block SHALL go to DONE; accept at edge k yields out_valid=1 after edge k+WIDTH/4 (4 cycles for WIDTH=16).
REQ-020 DONE: out_valid=1, in_ready=0; diff, b_out, zero, ovf SHALL hold stable until out_ready=1.
REQ-021 DONE with out_ready=1 at an edge: transfer completes, next state IDLE; a new operand set is accepted no earlier than the following cycle.
REQ-022 in_valid SHALL be ignored in BUSY and DONE; operand changes after capture SHALL not affect the result.
REQ-023 Result outputs outside DONE are don't-care for consumers but SHALL not toggle except during BUSY updates.
REQ-024 zero SHALL be evaluated on the complete WIDTH-bit diff, valid in DONE.
REQ-025 Throughput: one result per WIDTH/4+2 cycles with out_ready held 1.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, in_ready=1 thereafter, out_valid=0, diff=0, b_out=0, zero=0, ovf=0, counter=0, carry=0.
REQ-027 Reset during BUSY or DONE SHALL abandon the operation; no out_valid SHALL assert for it.
REQ-028 in_valid during reset SHALL not be captured.
REQ-029 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 Macro SUB_SEQ_OVF_EN: defined -> port ovf exists, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), b_in included in diff, valid in DONE; undefined -> port ovf and its logic absent, all other behaviour identical.

Verification
REQ-031 WIDTH=16: a=0x1234, b=0x0234, b_in=0 -> diff=0x1000, b_out=0, zero=0, out_valid 4 cycles after accept.
REQ-032 a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, zero=0; with SUB_SEQ_OVF_EN ovf=0.
REQ-033 a=0x5555, b=0x5554, b_in=1 -> diff=0x0000, b_out=0, zero=1.
REQ-034 SUB_SEQ_OVF_EN defined, a=0x8000, b=0x0001, b_in=0 -> diff=0x7FFF, b_out=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, ovf=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and changing a/b -> outputs stable, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n=0 for one cycle on 2nd BUSY cycle -> IDLE, out_valid never asserts for aborted op; next op 0x0010-0x0001 -> diff=0x000F, b_out=0.
